uart_cmd_assembler: RTL and testbench

Packet assembler sitting directly downstream of `UART_rcv` in the quadcopter command path. It consumes received bytes via the `rdy`/`clr_rdy` handshake, assembles each 3-byte packet (opcode, data high, data low) into a registered command word, and presents it to the command-processing logic with a `cmd_rdy`/`clr_cmd_rdy` handshake. Partial packets are discarded after an inter-byte timeout so a dropped byte cannot permanently misalign framing.

---
 rtl/uart_cmd_assembler.sv | 162 ++++++++++++++++
 tb/tb_uart_cmd_assembler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: frames UART bytes into {opcode, data_hi, data_lo} command words.
// Latency: cmd_rdy/cmd/data are registered at the edge that accepts the final byte of a packet.
// Backpressure: none toward UART_rcv (each byte is acked by a one-cycle clr_rx_rdy pulse); cmd_rdy is held until acked or the next opcode is accepted.
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   rx_data, rx_rdy      byte and byte-ready flag from UART_rcv
//   clr_rx_rdy           one-cycle acknowledge to UART_rcv.clr_rdy
//   clr_cmd_rdy          consumer acknowledge for the held command
//   cmd_rdy, cmd, data   completed packet: opcode and {data high, data low}
//   pkt_err              one-cycle pulse when a packet is discarded
// Optional feature: define CMD_CHECKSUM_EN for 4-byte packets whose bytes must sum to 8'hFF.
module uart_cmd_assembler #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        pkt_err
);

`ifdef CMD_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, DHI, DLO, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, DHI, DLO} state_t;
`endif

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  hi_q, hi_d;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  csum;
`endif
  logic        clr_rx_rdy_q, clr_rx_rdy_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic        pkt_err_q, pkt_err_d;
  logic        accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      op_q         <= '0;
      hi_q         <= '0;
`ifdef CMD_CHECKSUM_EN
      lo_q         <= '0;
`endif
      clr_rx_rdy_q <= 1'b0;
      cmd_rdy_q    <= 1'b0;
      cmd_q        <= '0;
      data_q       <= '0;
      pkt_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      op_q         <= op_d;
      hi_q         <= hi_d;
`ifdef CMD_CHECKSUM_EN
      lo_q         <= lo_d;
`endif
      clr_rx_rdy_q <= clr_rx_rdy_d;
      cmd_rdy_q    <= cmd_rdy_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      pkt_err_q    <= pkt_err_d;
    end
  end

  always_comb begin
    // rx_rdy is still high while our ack pulse is out; masking it keeps a byte from being taken twice.
    accept       = rx_rdy && !clr_rx_rdy_q;
    state_d      = state_q;
    tmo_d        = tmo_q;
    op_d         = op_q;
    hi_d         = hi_q;
`ifdef CMD_CHECKSUM_EN
    lo_d         = lo_q;
    csum         = op_q + hi_q + lo_q + rx_data;
`endif
    clr_rx_rdy_d = accept;
    cmd_rdy_d    = cmd_rdy_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    pkt_err_d    = 1'b0;

    // Ack first so that a completion or new opcode below overrides it.
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;

    if (accept) begin
      // A byte landing on the timeout cycle wins: the counter restarts and framing continues.
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          op_d      = rx_data;
          cmd_rdy_d = 1'b0;
          state_d   = DHI;
        end
        DHI: begin
          hi_d    = rx_data;
          state_d = DLO;
        end
`ifdef CMD_CHECKSUM_EN
        DLO: begin
          lo_d    = rx_data;
          state_d = CHK;
        end
        CHK: begin
          if (csum == 8'hFF) begin
            cmd_d     = op_q;
            data_d    = {hi_q, lo_q};
            cmd_rdy_d = 1'b1;
          end else begin
            pkt_err_d = 1'b1;
          end
          state_d = IDLE;
        end
`else
        DLO: begin
          cmd_d     = op_q;
          data_d    = {hi_q, rx_data};
          cmd_rdy_d = 1'b1;
          state_d   = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_LAST) begin
        // Abandon the partial packet; the last good command stays on the outputs.
        state_d   = IDLE;
        tmo_d     = '0;
        op_d      = '0;
        hi_d      = '0;
`ifdef CMD_CHECKSUM_EN
        lo_d      = '0;
`endif
        pkt_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end
  end

  assign clr_rx_rdy = clr_rx_rdy_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign cmd        = cmd_q;
  assign data       = data_q;
  assign pkt_err    = pkt_err_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Testbench for uart_cmd_assembler: table of packets plus hand-written corner sequences.
module tb_uart_cmd_assembler;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic        clr_cmd_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        pkt_err;

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;
  int err_cnt = 0;

  uart_cmd_assembler #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .clr_rx_rdy(clr_rx_rdy), .clr_cmd_rdy(clr_cmd_rdy), .cmd_rdy(cmd_rdy),
    .cmd(cmd), .data(data), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  // Cycle counts of the two pulse outputs.
  always @(posedge clk) begin
    if (clr_rx_rdy) clr_cnt <= clr_cnt + 1;
    if (pkt_err) err_cnt <= err_cnt + 1;
  end

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [7:0]  exp_cmd;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behaves like UART_rcv: holds rdy until acked, then waits out the ack cycle.
  task automatic send_byte(input logic [7:0] b);
    bit seen = 0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (clr_rx_rdy) seen = 1;
    end
    rx_rdy = 1'b0;
    if (!seen) chk("byte_ack_timeout", 0, 1);
    tick();
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo);
    send_byte(op);
    send_byte(hi);
    send_byte(lo);
`ifdef CMD_CHECKSUM_EN
    send_byte(8'hFF - op - hi - lo);
`endif
  endtask

  task automatic ack();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, e0;
    vecs[0] = '{8'h05, 8'h12, 8'h34, 8'h05, 16'h1234};
    vecs[1] = '{8'hA5, 8'h00, 8'hFF, 8'hA5, 16'h00FF};
    vecs[2] = '{8'hFF, 8'h80, 8'h01, 8'hFF, 16'h8001};
    vecs[3] = '{8'h3C, 8'hC3, 8'h5A, 8'h3C, 16'hC35A};

    // Reset with rx_rdy held high: nothing may be accepted.
    rst_n = 1'b0; rx_rdy = 1'b1; rx_data = 8'h55; clr_cmd_rdy = 1'b0;
    repeat (2) tick();
    chk("rst_clr_rx_rdy", clr_rx_rdy, 0);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_data", data, 0);
    chk("rst_pkt_err", pkt_err, 0);
    rx_rdy = 1'b0;
    rst_n  = 1'b1;
    tick();
    chk("rst_no_accept", clr_cnt, 0);

    // Table: nominal packets, each followed by a consumer ack.
    for (int i = 0; i < 4; i++) begin
      c0 = clr_cnt;
      e0 = err_cnt;
      send_pkt(vecs[i].op, vecs[i].hi, vecs[i].lo);
      chk($sformatf("v%0d_cmd_rdy", i), cmd_rdy, 1);
      chk($sformatf("v%0d_cmd", i), cmd, vecs[i].exp_cmd);
      chk($sformatf("v%0d_data", i), data, vecs[i].exp_data);
`ifdef CMD_CHECKSUM_EN
      chk($sformatf("v%0d_clr_pulses", i), clr_cnt - c0, 4);
`else
      chk($sformatf("v%0d_clr_pulses", i), clr_cnt - c0, 3);
`endif
      chk($sformatf("v%0d_no_err", i), err_cnt - e0, 0);
      ack();
      chk($sformatf("v%0d_ack_cmd_rdy", i), cmd_rdy, 0);
      chk($sformatf("v%0d_ack_cmd_held", i), cmd, vecs[i].exp_cmd);
      chk($sformatf("v%0d_ack_data_held", i), data, vecs[i].exp_data);
    end

    // Timeout on a partial packet; held command must survive.
    send_pkt(8'h11, 8'h22, 8'h33);
    chk("pre_tmo_cmd_rdy", cmd_rdy, 1);
    e0 = err_cnt;
    send_byte(8'h02);
    chk("tmo_opcode_clears_rdy", cmd_rdy, 0);
    send_byte(8'hAB);
    // Last accept was one edge ago plus one more; timeout pulse appears after TMO edges from accept.
    repeat (TMO - 2) tick();
    chk("tmo_not_yet", pkt_err, 0);
    tick();
    chk("tmo_pkt_err", pkt_err, 1);
    tick();
    chk("tmo_pkt_err_one_cycle", pkt_err, 0);
    chk("tmo_err_count", err_cnt - e0, 1);
    chk("tmo_cmd_held", cmd, 8'h11);
    chk("tmo_data_held", data, 16'h2233);
    chk("tmo_cmd_rdy_held", cmd_rdy, 0);
    send_pkt(8'h03, 8'h00, 8'h10);
    chk("post_tmo_cmd", cmd, 8'h03);
    chk("post_tmo_data", data, 16'h0010);
    chk("post_tmo_cmd_rdy", cmd_rdy, 1);

    // Back-to-back packets with no ack in between.
    send_pkt(8'h01, 8'h00, 8'h00);
    chk("b2b_first_rdy", cmd_rdy, 1);
    chk("b2b_first_cmd", cmd, 8'h01);
    send_byte(8'h7F);
    chk("b2b_rdy_falls", cmd_rdy, 0);
    chk("b2b_old_cmd_visible", cmd, 8'h01);
    chk("b2b_old_data_visible", data, 16'h0000);
    send_byte(8'hFF);
    send_byte(8'hFF);
`ifdef CMD_CHECKSUM_EN
    send_byte(8'h82);
`endif
    chk("b2b_second_rdy", cmd_rdy, 1);
    chk("b2b_second_cmd", cmd, 8'h7F);
    chk("b2b_second_data", data, 16'hFFFF);
    ack();

    // Completion and clr_cmd_rdy on the same edge: completion wins.
    send_byte(8'h44);
    send_byte(8'h55);
`ifdef CMD_CHECKSUM_EN
    send_byte(8'h66);
    rx_data = 8'hFF - 8'h44 - 8'h55 - 8'h66;
`else
    rx_data = 8'h66;
`endif
    rx_rdy = 1'b1;
    clr_cmd_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
    chk("sim_ack_clr_rx_rdy", clr_rx_rdy, 1);
    chk("sim_ack_cmd_rdy", cmd_rdy, 1);
    chk("sim_ack_cmd", cmd, 8'h44);
    chk("sim_ack_data", data, 16'h5566);
    tick();
    chk("sim_ack_rdy_stays", cmd_rdy, 1);

    // Byte accept on the very edge the timeout would fire.
    e0 = err_cnt;
    send_byte(8'h0A);
    repeat (TMO - 2) tick();
    rx_data = 8'h0B;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy = 1'b0;
    chk("coll_byte_taken", clr_rx_rdy, 1);
    chk("coll_no_pkt_err", pkt_err, 0);
    tick();
    send_byte(8'h0C);
`ifdef CMD_CHECKSUM_EN
    send_byte(8'hFF - 8'h0A - 8'h0B - 8'h0C);
`endif
    chk("coll_cmd_rdy", cmd_rdy, 1);
    chk("coll_cmd", cmd, 8'h0A);
    chk("coll_data", data, 16'h0B0C);
    chk("coll_err_count", err_cnt - e0, 0);
    ack();

`ifdef CMD_CHECKSUM_EN
    // Valid checksum packet, then a corrupted one.
    send_byte(8'h05); send_byte(8'h12); send_byte(8'h34); send_byte(8'hB4);
    chk("cs_ok_rdy", cmd_rdy, 1);
    chk("cs_ok_cmd", cmd, 8'h05);
    chk("cs_ok_data", data, 16'h1234);
    ack();
    e0 = err_cnt;
    send_byte(8'h06); send_byte(8'h77); send_byte(8'h88);
    rx_data = 8'hB5;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy = 1'b0;
    chk("cs_bad_pkt_err", pkt_err, 1);
    tick();
    chk("cs_bad_err_count", err_cnt - e0, 1);
    chk("cs_bad_rdy", cmd_rdy, 0);
    chk("cs_bad_cmd_held", cmd, 8'h05);
    chk("cs_bad_data_held", data, 16'h1234);
`endif

    // Mid-packet reset is silent.
    e0 = err_cnt;
    send_byte(8'h99);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (TMO + 4) tick();
    chk("rst_mid_no_err", err_cnt - e0, 0);
    chk("rst_mid_cmd", cmd, 8'h00);
    send_pkt(8'h21, 8'h43, 8'h65);
    chk("rst_mid_after_cmd", cmd, 8'h21);
    chk("rst_mid_after_data", data, 16'h4365);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
